// File: rtl/vcfg_unit.sv
// vcfg_unit: vsetvl-class vector configuration unit holding vl, vtype and
// strip-mining remaining-AVL state behind valid/ready request and response ports.
module vcfg_unit #(
   parameter int VLEN  = 64,
   parameter int ELEN  = 64,
   parameter int AVL_W = 32,
   parameter int VL_W  = $clog2(VLEN) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_cmd,
   input  logic [2:0]       req_sew,
   input  logic [2:0]       req_lmul,
   input  logic [AVL_W-1:0] req_avl,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [VL_W-1:0]  rsp_vl,
   output logic [VL_W-1:0]  vl,
   output logic [7:0]       vtype,
   output logic [AVL_W-1:0] avl_rem,
   output logic             strip_done
);
   localparam int CW = AVL_W > VL_W ? AVL_W : VL_W;
   localparam logic [1:0] CMD_KEEP = 2'b01, CMD_VLMAX = 2'b10, CMD_STRIP = 2'b11;
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t           state_q, state_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [2:0]       sew_q, sew_d, lmul_q, lmul_d;
   logic [AVL_W-1:0] avl_q, avl_d, avl_rem_q, avl_rem_d;
   logic [VL_W-1:0]  vl_q, vl_d, rsp_vl_q, rsp_vl_d;
   logic [7:0]       vtype_q, vtype_d;
   logic [2:0]       c_sew, c_lmul;
   logic [3:0]       frac_sh;
   logic [VL_W-1:0]  vlmax_base, vlmax;
   logic [AVL_W-1:0] src_avl;
   logic [CW-1:0]    take;
   logic             ill, bad;
   logic [VL_W-1:0]  res_vl;
   logic [AVL_W-1:0] res_rem;
   logic [7:0]       res_vtype;
   int               sew_bits;
   // STRIP re-derives VLMAX from the stored vtype rather than the request fields
   always_comb begin
      c_sew      = cmd_q == CMD_STRIP ? vtype_q[5:3] : sew_q;
      c_lmul     = cmd_q == CMD_STRIP ? vtype_q[2:0] : lmul_q;
      frac_sh    = 4'd8 - {1'b0, c_lmul};
      sew_bits   = 8 << c_sew;
      vlmax_base = VL_W'(VLEN >> (int'(c_sew) + 3));
      vlmax      = c_lmul[2] ? vlmax_base >> frac_sh : vlmax_base << c_lmul[1:0];
      ill        = c_sew[2] || c_lmul == 3'b100 || sew_bits > ELEN
                   || (c_lmul[2] && sew_bits > (ELEN >> frac_sh)) || vlmax == '0;
      src_avl    = cmd_q == CMD_STRIP ? avl_rem_q : avl_q;
      take       = CW'(src_avl) < CW'(vlmax) ? CW'(src_avl) : CW'(vlmax);
      bad        = ill || (cmd_q == CMD_STRIP && vtype_q[7])
                   || (cmd_q == CMD_KEEP && (vtype_q[7] || vl_q > vlmax));
      res_vl     = bad ? '0 : cmd_q == CMD_KEEP ? vl_q : cmd_q == CMD_VLMAX ? vlmax : VL_W'(take);
      res_rem    = bad || cmd_q == CMD_VLMAX ? '0
                   : cmd_q == CMD_KEEP ? avl_rem_q : src_avl - AVL_W'(take);
      res_vtype  = bad ? 8'h80 : {2'b00, c_sew, c_lmul};
   end
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      sew_d     = sew_q;
      lmul_d    = lmul_q;
      avl_d     = avl_q;
      vl_d      = vl_q;
      avl_rem_d = avl_rem_q;
      vtype_d   = vtype_q;
      rsp_vl_d  = rsp_vl_q;
      case (state_q)
         IDLE: if (req_valid) begin
            cmd_d   = req_cmd;
            sew_d   = req_sew;
            lmul_d  = req_lmul;
            avl_d   = req_avl;
            state_d = CALC;
         end
         CALC: begin
            vl_d      = res_vl;
            avl_rem_d = res_rem;
            vtype_d   = res_vtype;
            rsp_vl_d  = res_vl;
            state_d   = RESP;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         sew_q     <= '0;
         lmul_q    <= '0;
         avl_q     <= '0;
         vl_q      <= '0;
         avl_rem_q <= '0;
         vtype_q   <= 8'h80;
         rsp_vl_q  <= '0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         sew_q     <= sew_d;
         lmul_q    <= lmul_d;
         avl_q     <= avl_d;
         vl_q      <= vl_d;
         avl_rem_q <= avl_rem_d;
         vtype_q   <= vtype_d;
         rsp_vl_q  <= rsp_vl_d;
      end
   end
   assign req_ready  = state_q == IDLE;
   assign rsp_valid  = state_q == RESP;
   assign rsp_vl     = rsp_vl_q;
   assign vl         = vl_q;
   assign vtype      = vtype_q;
   assign avl_rem    = avl_rem_q;
   assign strip_done = avl_rem_q == '0;
endmodule

// File: tb/tb_vcfg_unit.sv
// tb_vcfg_unit: random and directed vsetvl traffic checked every cycle against a
// rule-level model of vl/vtype/avl_rem, plus literal expectations from the test plan.
module tb_vcfg_unit;
   localparam int VLEN = 64, ELEN = 64, AVL_W = 32, VL_W = $clog2(VLEN) + 1;
   logic             clk = 0, rst = 1;
   logic             req_valid = 0, req_ready;
   logic [1:0]       req_cmd = 0;
   logic [2:0]       req_sew = 0, req_lmul = 0;
   logic [AVL_W-1:0] req_avl = 0;
   logic             rsp_valid, rsp_ready = 0;
   logic [VL_W-1:0]  rsp_vl, vl;
   logic [7:0]       vtype;
   logic [AVL_W-1:0] avl_rem;
   logic             strip_done;
   vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN), .AVL_W(AVL_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_sew(req_sew), .req_lmul(req_lmul), .req_avl(req_avl),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vl(rsp_vl), .vl(vl),
      .vtype(vtype), .avl_rem(avl_rem), .strip_done(strip_done)
   );
   always #5 clk = ~clk;
   int vectors = 0, miscompares = 0;
   bit armed = 0, e_ready = 1, e_rvalid = 0, m_vill = 1;
   int m_vl = 0, m_sew = 0, m_lmul = 0, e_rsp_vl = 0;
   longint m_rem = 0;
   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endfunction
   function automatic int vlmax_of(int s, int l);
      int sewb;
      if (s > 3 || l == 4) return 0;
      sewb = 8 * (2 ** s);
      if (l < 4) return VLEN * (2 ** l) / sewb;
      return VLEN / (sewb * (2 ** (8 - l)));
   endfunction
   function automatic bit legal(int s, int l);
      if (s > 3 || l == 4 || 8 * (2 ** s) > ELEN) return 0;
      if (l > 4 && 8 * (2 ** s) * (2 ** (8 - l)) > ELEN) return 0;
      return vlmax_of(s, l) > 0;
   endfunction
   function automatic void model_reset();
      m_vill = 1; m_vl = 0; m_rem = 0; m_sew = 0; m_lmul = 0;
   endfunction
   function automatic void model_apply(int c, int s, int l, longint a);
      int vm;
      if (c == 3) begin s = m_sew; l = m_lmul; end
      vm = vlmax_of(s, l);
      if (!legal(s, l) || (c == 3 && m_vill) || (c == 1 && (m_vill || m_vl > vm))) begin
         model_reset();
         return;
      end
      m_vill = 0; m_sew = s; m_lmul = l;
      if (c == 0) begin m_vl = a < vm ? int'(a) : vm; m_rem = a - m_vl; end
      else if (c == 2) begin m_vl = vm; m_rem = 0; end
      else if (c == 3) begin m_vl = m_rem < vm ? int'(m_rem) : vm; m_rem -= m_vl; end
   endfunction
   function automatic logic [7:0] exp_vtype();
      logic [7:0] v;
      v = {2'b00, 3'(m_sew), 3'(m_lmul)};
      return m_vill ? 8'h80 : v;
   endfunction
   always @(negedge clk) if (armed) begin
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rvalid);
      chk("vl", vl, m_vl);
      chk("vtype", vtype, exp_vtype());
      chk("avl_rem", avl_rem, m_rem);
      chk("strip_done", strip_done, m_rem == 0);
      if (e_rvalid) chk("rsp_vl", rsp_vl, e_rsp_vl);
   end
   task automatic req(input int c, input int s, input int l, input logic [AVL_W-1:0] a,
                      input int hold, input bit junk);
      req_valid = 1; req_cmd = 2'(c); req_sew = 3'(s); req_lmul = 3'(l); req_avl = a;
      @(posedge clk); #1;
      e_ready = 0;
      req_valid = junk;
      if (junk) begin
         req_cmd = 2'($urandom); req_sew = 3'($urandom); req_lmul = 3'($urandom); req_avl = $urandom;
      end
      @(posedge clk); #1;
      model_apply(c, s, l, longint'(a));
      e_rvalid = 1; e_rsp_vl = m_vl;
      rsp_ready = 0;
      repeat (hold) begin @(posedge clk); #1; end
      rsp_ready = 1;
      @(posedge clk); #1;
      e_rvalid = 0; e_ready = 1; req_valid = 0; rsp_ready = 0;
   endtask
   task automatic reset_in_calc(input int c, input int s, input int l, input logic [AVL_W-1:0] a);
      req_valid = 1; req_cmd = 2'(c); req_sew = 3'(s); req_lmul = 3'(l); req_avl = a;
      @(posedge clk); #1;
      e_ready = 0; req_valid = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0; model_reset(); e_ready = 1; e_rvalid = 0;
   endtask
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask
   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0; armed = 1;
      chk("rst_vtype", vtype, 8'h80);
      chk("rst_vl", vl, 0);
      chk("rst_strip_done", strip_done, 1);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_vl", rsp_vl, 0);
      req(0, 1, 1, 20, 0, 0);
      chk("set_vl", vl, 8); chk("set_rem", avl_rem, 12); chk("set_vtype", vtype, 8'h09);
      req(3, 0, 0, 0, 0, 0);
      chk("strip1_vl", vl, 8); chk("strip1_rem", avl_rem, 4);
      req(3, 0, 0, 0, 1, 0);
      chk("strip2_vl", vl, 4); chk("strip2_rem", avl_rem, 0); chk("strip2_done", strip_done, 1);
      req(3, 0, 0, 0, 0, 0);
      chk("strip3_vl", vl, 0); chk("strip3_rem", avl_rem, 0); chk("strip3_vtype", vtype, 8'h09);
      req(0, 0, 7, 10, 0, 0);
      chk("frac_vl", vl, 4); chk("frac_rem", avl_rem, 6);
      req(0, 3, 7, 10, 0, 0);
      chk("frac_vill_vtype", vtype, 8'h80); chk("frac_vill_vl", vl, 0);
      req(0, 2, 2, 100, 0, 0);
      chk("pre_keep_vl", vl, 8);
      req(1, 0, 0, 0, 0, 0);
      chk("keep_vl", vl, 8); chk("keep_vtype", vtype, 8'h00);
      req(1, 3, 0, 0, 0, 0);
      chk("keep_vill_vtype", vtype, 8'h80); chk("keep_vill_vl", vl, 0);
      req(0, 1, 1, 20, 5, 1);
      chk("bp_vl", vl, 8);
      reset_in_calc(0, 0, 0, 50);
      chk("rcalc_vl", vl, 0); chk("rcalc_vtype", vtype, 8'h80);
      chk("rcalc_rem", avl_rem, 0); chk("rcalc_rsp_vl", rsp_vl, 0);
      for (int i = 0; i < 400; i++) begin
         int c, s, l, hold;
         logic [AVL_W-1:0] a;
         idle($urandom_range(0, 2));
         c = $urandom_range(0, 3);
         s = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 3);
         l = $urandom_range(0, 7);
         a = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 80);
         hold = $urandom_range(0, 3);
         if ($urandom_range(0, 29) == 0) reset_in_calc(c, s, l, a);
         else req(c, s, l, a, hold, 1'($urandom_range(0, 1)));
      end
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
